// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pkg: opcodes, control state and datapath mux encodings (RV32I).      |
// | Revision: 1.0  -- ST_TRAP exists only with RISCV_CTRL_ILLEGAL_TRAP_EN.     |
// +----------------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXECR  = 4'd7,
    ST_EXECI  = 4'd8,
    ST_ALUWB  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JAL    = 4'd11,
    ST_LUI    = 4'd12
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    , ST_TRAP = 4'd13
`endif
  } state_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

endpackage
`default_nettype wire

// File: rtl/riscv_multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_multicycle_ctrl_if: unified memory port request/ready handshake.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface riscv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/riscv_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_ctrl_decode: opcode -> state that follows DECODE (combinational).    |
// | Revision: 1.0  -- RISCV_CTRL_ILLEGAL_TRAP_EN routes unknown opcodes to TRAP|
// +----------------------------------------------------------------------------+
module riscv_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output state_e     next_state
);

  always_comb begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    next_state = ST_TRAP;
`else
    // PC is already advanced, so falling back to FETCH makes it a NOP.
    next_state = ST_FETCH;
`endif
    case (opcode)
      OPC_LOAD, OPC_STORE: next_state = ST_MEMADR;
      OPC_OP:              next_state = ST_EXECR;
      OPC_OPIMM:           next_state = ST_EXECI;
      OPC_BRANCH:          next_state = ST_BRANCH;
      OPC_JAL:             next_state = ST_JAL;
      OPC_LUI:             next_state = ST_LUI;
      default:             ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_multicycle_ctrl: RV32I multicycle sequencer, Moore-decoded controls. |
// | Revision: 1.0  -- optional RISCV_CTRL_ILLEGAL_TRAP_EN adds TRAP + illegal. |
// +----------------------------------------------------------------------------+
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  riscv_multicycle_ctrl_if.master    mem,
  input  logic [6:0]                 opcode,
  input  logic                       zero,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       reg_write,
  output logic [1:0]                 alu_src_a,
  output logic [1:0]                 alu_src_b,
  output logic [1:0]                 alu_op,
  output logic [1:0]                 result_src,
  output logic [CNT_W-1:0]           instret,
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  output logic                       illegal,
`endif
  output logic [3:0]                 state
);

  state_e           state_q, state_d;
  state_e           decode_next;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             req, we, addr_sel;

  riscv_ctrl_decode u_decode (
    .opcode     (opcode),
    .next_state (decode_next)
  );

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        req        = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem.mem_ready;
        pc_write   = mem.mem_ready;
        if (mem.mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_d   = decode_next;
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OPC_STORE) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        if (mem.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWR: begin
        req      = 1'b1;
        we       = 1'b1;
        addr_sel = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_ALUWB;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_ALUWB;
      end
      ST_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_d   = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JAL: begin
        // ALUOut still holds the DECODE target; ALU now forms OldPC+4 for rd.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = ST_ALUWB;
      end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb illegal_d = illegal_q | (state_d == ST_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign mem.iord    = addr_sel;
  assign instret     = instret_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_multicycle_ctrl: randomized self-checking bench for the sequencer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_riscv_multicycle_ctrl;
  import riscv_pkg::*;

  typedef struct packed {
    logic       req, we, iord, irw, pcw, regw;
    logic [1:0] a, b, op, res;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instret;
  logic [3:0]  state;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = 32'd0;

  riscv_multicycle_ctrl_if mif ();

  riscv_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mif),
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .instret    (instret),
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    .illegal    (illegal),
`endif
    .state      (state)
  );

  always #5 clk = ~clk;

  // Per-state control table, written straight from the state descriptions.
  function automatic outs_t spec_out(input state_e s, input logic rdy, input logic z);
    outs_t o = '0;
    case (s)
      ST_FETCH:  begin o.req = 1; o.irw = rdy; o.pcw = rdy; o.b = 2'b10; o.res = 2'b10; end
      ST_DECODE: begin o.a = 2'b01; o.b = 2'b01; end
      ST_MEMADR: begin o.a = 2'b10; o.b = 2'b01; end
      ST_MEMRD:  begin o.req = 1; o.iord = 1; end
      ST_MEMWB:  begin o.res = 2'b01; o.regw = 1; end
      ST_MEMWR:  begin o.req = 1; o.we = 1; o.iord = 1; end
      ST_EXECR:  begin o.a = 2'b10; o.op = 2'b10; end
      ST_EXECI:  begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; end
      ST_LUI:    begin o.a = 2'b11; o.b = 2'b01; end
      ST_ALUWB:  o.regw = 1;
      ST_BRANCH: begin o.a = 2'b10; o.op = 2'b01; o.pcw = z; end
      ST_JAL:    begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1; end
      default:   ;
    endcase
    return o;
  endfunction

  function automatic outs_t observed();
    return {mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, alu_op, result_src};
  endfunction

  // Hold reset for a few cycles, release it, and check the single IDLE cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mif.mem_ready = 1'b1;
      zero = 1'($urandom);
      #2;
      total++;
      if (state !== 4'(ST_IDLE) || observed() !== outs_t'(0) || instret !== 32'd0) begin
        bad++;
        $display("FAIL reset_hold state=%0d outs=%h instret=%0d want state=%0d outs=0 instret=0",
                 state, observed(), instret, ST_IDLE);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    total++;
    if (state !== 4'(ST_IDLE) || observed() !== outs_t'(0)) begin
      bad++;
      $display("FAIL reset_release_idle state=%0d outs=%h want state=%0d outs=0",
               state, observed(), ST_IDLE);
    end
    exp_instret = 32'd0;
  endtask

  // Runs one instruction: the expected state list comes from the instruction
  // class plus the number of wait cycles inserted on each memory access.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm,
                           input int zmode, input int abort_at);
    state_e seq[$];
    logic   rdy[$];
    logic   do_retire = 1'b1;
    for (int i = 0; i < wf; i++) begin seq.push_back(ST_FETCH); rdy.push_back(1'b0); end
    seq.push_back(ST_FETCH);  rdy.push_back(1'b1);
    seq.push_back(ST_DECODE); rdy.push_back(1'($urandom));
    case (op)
      OPC_LOAD, OPC_STORE: begin
        seq.push_back(ST_MEMADR); rdy.push_back(1'($urandom));
        for (int i = 0; i <= wm; i++) begin
          seq.push_back(op == OPC_LOAD ? ST_MEMRD : ST_MEMWR);
          rdy.push_back(i == wm);
        end
        if (op == OPC_LOAD) begin seq.push_back(ST_MEMWB); rdy.push_back(1'($urandom)); end
      end
      OPC_OP:     begin seq.push_back(ST_EXECR); seq.push_back(ST_ALUWB); rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom)); end
      OPC_OPIMM:  begin seq.push_back(ST_EXECI); seq.push_back(ST_ALUWB); rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom)); end
      OPC_LUI:    begin seq.push_back(ST_LUI);   seq.push_back(ST_ALUWB); rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom)); end
      OPC_JAL:    begin seq.push_back(ST_JAL);   seq.push_back(ST_ALUWB); rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom)); end
      OPC_BRANCH: begin seq.push_back(ST_BRANCH); rdy.push_back(1'($urandom)); end
      default: begin
        do_retire = 1'b0;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin seq.push_back(ST_TRAP); rdy.push_back(1'($urandom)); end
`endif
      end
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk); #1;
      opcode = op;
      mif.mem_ready = rdy[i];
      zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      #2;
      total++;
      if (state !== 4'(seq[i])) begin
        bad++;
        $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, i, state, seq[i]);
      end
      total++;
      if (observed() !== spec_out(seq[i], rdy[i], zero)) begin
        bad++;
        $display("FAIL outputs op=%b cyc=%0d got=%h want=%h", op, i, observed(),
                 spec_out(seq[i], rdy[i], zero));
      end
      total++;
      if (instret !== exp_instret) begin
        bad++;
        $display("FAIL instret op=%b cyc=%0d got=%0d want=%0d", op, i, instret, exp_instret);
      end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      total++;
      if (illegal !== (seq[i] == ST_TRAP)) begin
        bad++;
        $display("FAIL illegal_flag cyc=%0d got=%b want=%b", i, illegal, seq[i] == ST_TRAP);
      end
`endif
      if (i == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 4'(ST_IDLE) || observed() !== outs_t'(0) || instret !== 32'd0) begin
          bad++;
          $display("FAIL async_abort state=%0d outs=%h instret=%0d want state=%0d outs=0 instret=0",
                   state, observed(), instret, ST_IDLE);
        end
        exp_instret = 32'd0;
        return;
      end
    end
    if (do_retire) exp_instret = exp_instret + 32'd1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_load();
    run_instr(OPC_LOAD, 0, 2, 2, -1);
  endtask

  task automatic test_branch();
    run_instr(OPC_BRANCH, 0, 0, 1, -1);
    run_instr(OPC_BRANCH, 0, 0, 0, -1);
  endtask

  task automatic test_jal();
    run_instr(OPC_JAL, 0, 0, 2, -1);
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 0, 0, 2, -1);
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    do_reset();
`endif
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [7];
    ops = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_LUI};
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 2, -1);
  endtask

  task automatic test_reset_mid_memwr();
    run_instr(OPC_STORE, 0, 3, 2, 5);
    do_reset();
    run_instr(OPC_LOAD, 1, 1, 2, -1);
    run_instr(OPC_OPIMM, 0, 0, 2, -1);
  endtask

  initial begin
    mif.mem_ready = 1'b1;
    test_reset();
    test_load();
    test_branch();
    test_jal();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multicycle control unit for the RV32I core. It sequences the shared datapath (PC, instruction register, unified memory port, register file, ALU and the immediate generator) one state per clock. It decodes the registered opcode, drives every mux select and write enable, waits on a ready/request memory handshake, and counts retired instructions. It supports the opcode set the immediate generator already handles (LUI, OP-IMM, LOAD, STORE, BRANCH, JAL) plus R-type OP.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register.
- `zero`  in  1  ALU zero flag, used in BRANCH.
- `mem_ready`  in  1  memory has completed the current request this cycle.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR and OldPC.
- `pc_write`  out  1  load PC.
- `reg_write`  out  1  register-file write.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- `alu_src_b`  out  2  00 rs2, 01 Imm, 10 constant 4.
- `alu_op`  out  2  00 add, 01 sub, 10 funct-decoded.
- `result_src`  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- `instret`  out  CNT_W  retired-instruction count.
- `illegal`  out  1  sticky flag for an illegal opcode (present only with the macro).
- `state`  out  4  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP.
- Outputs are Moore-decoded from the state. The only exceptions are `ir_write` and `pc_write` in FETCH, which are gated by `mem_ready`. Any output not listed for a state is 0.
- **IDLE**: all outputs 0. Goes to FETCH unconditionally.
- **FETCH**:
  - Drives `mem_req=1`, `iord=0`, `alu_src_a=00`, `alu_src_b=10`, `alu_op=00`, `result_src=10`.
  - When `mem_ready=1`, also asserts `ir_write` and `pc_write`, then goes to DECODE. Otherwise stays in FETCH.
- **DECODE**: drives `alu_src_a=01`, `alu_src_b=01`, `alu_op=00` to compute the branch target. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - any other opcode → see Configuration.
- **MEMADR**: `alu_src_a=10`, `alu_src_b=01`, add. Goes to MEMRD for a load, MEMWR for a store.
- **MEMRD**: `mem_req=1`, `iord=1`. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**: `result_src=01`, `reg_write=1`. Goes to FETCH.
- **MEMWR**: `mem_req=1`, `mem_we=1`, `iord=1`. Waits for `mem_ready`, then goes to FETCH.
- **EXECR**: `alu_src_a=10`, `alu_src_b=00`, `alu_op=10`. Goes to ALUWB.
- **EXECI**: `alu_src_a=10`, `alu_src_b=01`, `alu_op=10`. Goes to ALUWB.
- **LUI**: `alu_src_a=11`, `alu_src_b=01`, add. Goes to ALUWB.
- **ALUWB**: `result_src=00`, `reg_write=1`. Goes to FETCH.
- **BRANCH**: `alu_src_a=10`, `alu_src_b=00`, `alu_op=01`, `result_src=00`, `pc_write=zero`. Goes to FETCH.
- **JAL**: `alu_src_a=01`, `alu_src_b=10`, add, `result_src=00`, `pc_write=1`. Goes to ALUWB, which writes rd = OldPC+4.
- **Retire**: `instret` increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH. It wraps modulo 2^CNT_W.

## Timing
- Reset:
  - While `rst_n=0`, the state is IDLE, all outputs are 0 and `instret=0`.
  - Assertion during any state, including a pending memory wait, aborts the sequence immediately with no write.
  - The first `mem_req` appears one cycle after reset release.
- A memory wait in FETCH, MEMRD or MEMWR holds every output stable until `mem_ready=1`.
- `mem_ready` is ignored in states where `mem_req=0`.
- CPI with zero-wait memory (`mem_ready` tied high): LOAD 5, STORE 4, OP/OP-IMM/LUI/JAL 4, BRANCH 3. Each wait cycle on a memory access adds one.

## Configuration
- `RISCV_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP drives all outputs 0, sets `illegal=1` and stays there until reset.
  - `instret` is not incremented.
- Macro undefined:
  - An unknown opcode in DECODE goes directly to FETCH, so it executes as a NOP (PC already advanced) and does not retire.
  - The `illegal` port and the TRAP state are absent.

## Structure
- Package `riscv_pkg`: opcode constants, the state enum (4-bit), and the `alu_src_a`, `alu_src_b`, `alu_op` and `result_src` encodings. The datapath muxes share these.
- One sub-module, `riscv_ctrl_decode`: combinational opcode → next-state-from-DECODE lookup. All sequencing stays in the top level.

## Test plan
- Reset, then release with `mem_ready=1` → IDLE for 1 cycle, then FETCH with `mem_req=1`, `ir_write=1`, `pc_write=1`, `instret=0`.
- LOAD (0000011) with `mem_ready` low for 2 cycles in MEMRD → state sequence FETCH, DECODE, MEMADR, MEMRD×3, MEMWB. `reg_write=1` only in MEMWB, `result_src=01`, and `instret` goes 0→1.
- BRANCH (1100011), run twice, with `zero=1` then `zero=0` → `pc_write=1` in BRANCH the first time only. Each instruction takes 3 cycles and `instret` increments.
- JAL (1101111) → JAL asserts `pc_write=1`, `alu_src_b=10`, then ALUWB asserts `reg_write=1`, 4 cycles total.
- Opcode 1111111 → with the macro: TRAP, `illegal=1`, `mem_req` stays 0 for 20 cycles. Without the macro: back to FETCH after DECODE, `instret` unchanged.
- Reset asserted mid-MEMWR → all outputs 0 immediately, no `mem_we` after release, `instret=0`.
